pair_combiner: RTL and testbench

- Join stage that merges two independent valid/ready streams into one stream carrying the concatenated word {data1, data0}.
- Sits downstream of a two-way broadcast split and its per-lane processing, and re-joins the two lanes for the next stage.
- Each lane has a one-entry capture slot, so the two lanes may arrive skewed by any number of cycles.
- A registered output buffer breaks every combinational path from iReady_BM to the input readies.

---
 rtl/pair_combiner_pkg.sv | 17 +
 rtl/pair_combiner_obuf.sv | 83 ++++++++
 rtl/pair_combiner.sv | 102 ++++++++++
 tb/tb_pair_combiner.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/pair_combiner_pkg.sv
// Shared constants for the pair_combiner join stage.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package pair_combiner_pkg;

  // Output buffer modes: "yes" is a 2-entry buffer for full rate, "no" a single entry.
  // Any other string behaves like "yes".
  localparam string BURST_YES = "yes";
  localparam string BURST_NO  = "no";

  // Buffer occupancy counter: holds 0..2.
  localparam int CNT_W = 2;

  // Width of the optional output-handshake counter.
  localparam int STAT_W = 32;

endpackage

// File: rtl/pair_combiner_obuf.sv
// Registered 1- or 2-entry output buffer with valid/ready on both sides.
// Latency: a push is visible on pop_vld_o/pop_dat_o the cycle after the push edge.
// Backpressure: push_rdy_o depends only on the registered count, never on pop_rdy_i.
module pair_combiner_obuf
  import pair_combiner_pkg::*;
#(
  parameter int    WIDTH = 64,
  parameter string BURST = BURST_YES
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_vld_i,
  output logic             push_rdy_o,
  input  logic [WIDTH-1:0] push_dat_i,
  output logic             pop_vld_o,
  input  logic             pop_rdy_i,
  output logic [WIDTH-1:0] pop_dat_o
);

  // Only the exact string "no" selects the single-entry variant.
  localparam bit SINGLE = (BURST == BURST_NO);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] head_q, head_d;  // oldest entry, drives the output
  logic [WIDTH-1:0] tail_q, tail_d;  // second entry, used only in burst mode
  logic             push, pop;

  // Acceptance, occupancy update and entry shifting; head is always the oldest pair.
  always_comb begin
    cnt_d  = cnt_q;
    head_d = head_q;
    tail_d = tail_q;

    // Ready is a pure function of the registered count so the output ready
    // never reaches the upstream readies combinationally.
    if (SINGLE) begin
      push_rdy_o = (cnt_q == CNT_W'(0));
    end else begin
      push_rdy_o = (cnt_q < CNT_W'(2));
    end
    pop_vld_o = (cnt_q != CNT_W'(0));

    push = push_vld_i && push_rdy_o;
    pop  = pop_vld_o && pop_rdy_i;

    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;  // idle, or push and pop together
    endcase

    // With two entries held only a pop can happen: tail moves up to head.
    if (pop && (cnt_q == CNT_W'(2))) begin
      head_d = tail_q;
    end

    // A push lands in head when the buffer is (or is becoming) empty,
    // otherwise behind the current head.
    if (push) begin
      if ((cnt_q == CNT_W'(0)) || ((cnt_q == CNT_W'(1)) && pop)) begin
        head_d = push_dat_i;
      end else begin
        tail_d = push_dat_i;
      end
    end
  end

  assign pop_dat_o = head_q;

  // Buffer state registers with synchronous active-low clear.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      head_q <= '0;
      tail_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

endmodule

// File: rtl/pair_combiner.sv
// Joins two valid/ready lanes into one {lane1, lane0} stream; optional PAIR_COMBINER_STAT_EN adds oPairCount.
// Latency: both lanes accepted at edge E -> pair pushed at E+1 -> oValid_BM high after E+1.
// Backpressure: lane readies drop while its slot is full and cannot drain; no path from iReady_BM.
module pair_combiner
  import pair_combiner_pkg::*;
#(
  parameter int    WIDTH0 = 32,
  parameter int    WIDTH1 = 32,
  parameter string BURST  = BURST_YES
) (
  input  logic                     iCLK,
  input  logic                     iRST,
  input  logic                     iValid_AM0,
  output logic                     oReady_AM0,
  input  logic [WIDTH0-1:0]        iData_AM0,
  input  logic                     iValid_AM1,
  output logic                     oReady_AM1,
  input  logic [WIDTH1-1:0]        iData_AM1,
  output logic                     oValid_BM,
  input  logic                     iReady_BM,
  output logic [WIDTH1+WIDTH0-1:0] oData_BM
`ifdef PAIR_COMBINER_STAT_EN
  ,
  output logic [STAT_W-1:0]        oPairCount
`endif
);

  // One capture slot per lane so the lanes may arrive with arbitrary skew.
  logic              v0_q, v0_d;
  logic              v1_q, v1_d;
  logic [WIDTH0-1:0] d0_q, d0_d;
  logic [WIDTH1-1:0] d1_q, d1_d;

  logic buf_rdy;
  logic drain;
  logic acc0, acc1;

  // Slot control: a slot refills in the same cycle it drains, so streaming
  // lanes never lose a cycle while the buffer has room.
  always_comb begin
    drain      = v0_q && v1_q && buf_rdy;
    oReady_AM0 = iRST && (!v0_q || drain);
    oReady_AM1 = iRST && (!v1_q || drain);
    acc0       = iValid_AM0 && oReady_AM0;
    acc1       = iValid_AM1 && oReady_AM1;

    v0_d = acc0 || (v0_q && !drain);
    v1_d = acc1 || (v1_q && !drain);
    d0_d = acc0 ? iData_AM0 : d0_q;
    d1_d = acc1 ? iData_AM1 : d1_q;
  end

  // Slot registers; reset discards any half-formed pair.
  always_ff @(posedge iCLK) begin
    if (!iRST) begin
      v0_q <= 1'b0;
      v1_q <= 1'b0;
      d0_q <= '0;
      d1_q <= '0;
    end else begin
      v0_q <= v0_d;
      v1_q <= v1_d;
      d0_q <= d0_d;
      d1_q <= d1_d;
    end
  end

  pair_combiner_obuf #(
    .WIDTH (WIDTH1 + WIDTH0),
    .BURST (BURST)
  ) u_obuf (
    .clk_i      (iCLK),
    .rst_ni     (iRST),
    .push_vld_i (v0_q && v1_q),
    .push_rdy_o (buf_rdy),
    .push_dat_i ({d1_q, d0_q}),
    .pop_vld_o  (oValid_BM),
    .pop_rdy_i  (iReady_BM),
    .pop_dat_o  (oData_BM)
  );

`ifdef PAIR_COMBINER_STAT_EN
  logic [STAT_W-1:0] pair_cnt_q, pair_cnt_d;

  // Output handshake count; wraps naturally at 2^STAT_W.
  always_comb begin
    pair_cnt_d = pair_cnt_q + STAT_W'(oValid_BM && iReady_BM);
  end

  // Counter register, cleared by reset.
  always_ff @(posedge iCLK) begin
    if (!iRST) begin
      pair_cnt_q <= '0;
    end else begin
      pair_cnt_q <= pair_cnt_d;
    end
  end

  assign oPairCount = pair_cnt_q;
`endif

endmodule

// File: tb/tb_pair_combiner.sv
// Self-checking bench for pair_combiner: directed steps plus a randomized phase.
// Latency: n/a (testbench).
// Backpressure: drives iReady_BM directly, including long stalls.
module tb_pair_combiner;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;

  // Instance A: burst "yes"
  logic        a_v0, a_v1, a_r0, a_r1, a_ov, a_or;
  logic [31:0] a_d0, a_d1;
  logic [63:0] a_od;
  // Instance B: burst "no"
  logic        b_v0, b_v1, b_r0, b_r1, b_ov, b_or;
  logic [31:0] b_d0, b_d1;
  logic [63:0] b_od;
`ifdef PAIR_COMBINER_STAT_EN
  logic [31:0] a_pc, b_pc;
`endif

  pair_combiner #(.WIDTH0(32), .WIDTH1(32), .BURST("yes")) dut_a (
    .iCLK(clk), .iRST(rst_n),
    .iValid_AM0(a_v0), .oReady_AM0(a_r0), .iData_AM0(a_d0),
    .iValid_AM1(a_v1), .oReady_AM1(a_r1), .iData_AM1(a_d1),
    .oValid_BM(a_ov), .iReady_BM(a_or), .oData_BM(a_od)
`ifdef PAIR_COMBINER_STAT_EN
    , .oPairCount(a_pc)
`endif
  );

  pair_combiner #(.WIDTH0(32), .WIDTH1(32), .BURST("no")) dut_b (
    .iCLK(clk), .iRST(rst_n),
    .iValid_AM0(b_v0), .oReady_AM0(b_r0), .iData_AM0(b_d0),
    .iValid_AM1(b_v1), .oReady_AM1(b_r1), .iData_AM1(b_d1),
    .oValid_BM(b_ov), .iReady_BM(b_or), .oData_BM(b_od)
`ifdef PAIR_COMBINER_STAT_EN
    , .oPairCount(b_pc)
`endif
  );

  int n_pass = 0;
  int n_total = 0;

  // Reference model for A: accepted words per lane, and pairs formed in order.
  logic [31:0] qa0[$];
  logic [31:0] qa1[$];
  logic [63:0] pa[$];
  int          a_out_cnt = 0;
  logic        a_stall_prev = 1'b0;
  logic [63:0] a_hold = '0;

  // Model for B: lane k's i-th accepted word is i (lane0) / 0x1000+i (lane1).
  int   b_in0 = 0, b_in1 = 0, b_out = 0;
  logic b_vprev = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // One clock cycle: sample handshakes at the falling edge, then cross the rising edge.
  task automatic tick();
    @(negedge clk);
    if (!rst_n) begin
      qa0.delete(); qa1.delete(); pa.delete();
      a_stall_prev = 1'b0;
      b_vprev = 1'b0;
      b_in0 = 0; b_in1 = 0; b_out = 0;
    end else begin
      if (a_stall_prev) begin
        chk("a_hold_vld", 64'(a_ov), 64'd1);
        chk("a_hold_dat", a_od, a_hold);
      end
      if (a_ov && a_or) begin
        chk("a_out_expected", 64'(pa.size() != 0), 64'd1);
        if (pa.size() != 0) chk("a_out_dat", a_od, pa.pop_front());
        a_out_cnt++;
      end
      a_stall_prev = a_ov && !a_or;
      a_hold = a_od;
      if (a_v0 && a_r0) qa0.push_back(a_d0);
      if (a_v1 && a_r1) qa1.push_back(a_d1);
      while (qa0.size() != 0 && qa1.size() != 0) pa.push_back({qa1.pop_front(), qa0.pop_front()});
      chk("a_slot_cap", 64'(qa0.size() <= 1 && qa1.size() <= 1), 64'd1);
      chk("a_occupancy", 64'(pa.size() <= 3), 64'd1);

      if (b_ov && b_or) begin
        chk("b_out_dat", b_od, {32'h1000 + 32'(b_out), 32'(b_out)});
        b_out++;
      end
      chk("b_no_back2back", 64'(b_vprev && b_ov), 64'd0);
      b_vprev = b_ov;
      if (b_v0 && b_r0) b_in0++;
      if (b_v1 && b_r1) b_in1++;
    end
    @(posedge clk);
    #1;
    b_d0 = 32'(b_in0);
    b_d1 = 32'h1000 + 32'(b_in1);
  endtask

  initial begin
    int n0;
    int hs0;
    rst_n = 1'b0;
    a_v0 = 1'b1; a_v1 = 1'b1; a_d0 = 32'h1; a_d1 = 32'h2; a_or = 1'b1;
    b_v0 = 1'b0; b_v1 = 1'b0; b_d0 = '0; b_d1 = 32'h1000; b_or = 1'b1;

    // Reset held for 3 cycles with valid inputs
    repeat (3) begin
      tick();
      chk("rst_rdy0", 64'(a_r0), 64'd0);
      chk("rst_rdy1", 64'(a_r1), 64'd0);
      chk("rst_vld", 64'(a_ov), 64'd0);
      chk("rst_dat", a_od, 64'd0);
    end
    rst_n = 1'b1;
    a_v0 = 1'b0; a_v1 = 1'b0;
    tick();
    chk("post_rst_rdy0", 64'(a_r0), 64'd1);
    chk("post_rst_rdy1", 64'(a_r1), 64'd1);

    // Aligned lanes
    a_v0 = 1'b1; a_v1 = 1'b1; a_d0 = 32'h11; a_d1 = 32'hA1;
    tick();
    chk("al_first_vld", 64'(a_ov), 64'd0);
    a_d0 = 32'h12; a_d1 = 32'hA2;
    tick();
    chk("al_vld1", 64'(a_ov), 64'd1);
    chk("al_dat1", a_od, 64'h0000_00A1_0000_0011);
    a_d0 = 32'h13; a_d1 = 32'hA3;
    tick();
    chk("al_dat2", a_od, 64'h0000_00A2_0000_0012);
    a_v0 = 1'b0; a_v1 = 1'b0;
    tick();
    chk("al_vld3", 64'(a_ov), 64'd1);
    chk("al_dat3", a_od, 64'h0000_00A3_0000_0013);
    tick();
    chk("al_idle", 64'(a_ov), 64'd0);

    // Skew: lane0 at cycle 0, lane1 at cycle 6
    a_v0 = 1'b1; a_d0 = 32'h5;
    tick();
    a_v0 = 1'b0;
    for (int t = 1; t <= 6; t++) begin
      if (t == 6) begin a_v1 = 1'b1; a_d1 = 32'h9; end
      chk("skew_rdy0", 64'(a_r0), 64'd0);
      chk("skew_novld", 64'(a_ov), 64'd0);
      tick();
    end
    a_v1 = 1'b0;
    chk("skew_novld7", 64'(a_ov), 64'd0);
    tick();
    chk("skew_vld8", 64'(a_ov), 64'd1);
    chk("skew_dat8", a_od, 64'h0000_0009_0000_0005);
    tick();
    chk("skew_single", 64'(a_ov), 64'd0);

    // Backpressure: output stalled for 5 cycles while both lanes stream
    a_or = 1'b0; a_v0 = 1'b1; a_v1 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      a_d0 = 32'h20 + 32'(i); a_d1 = 32'hB0 + 32'(i);
      tick();
    end
    chk("bp_rdy0", 64'(a_r0), 64'd0);
    chk("bp_rdy1", 64'(a_r1), 64'd0);
    chk("bp_vld", 64'(a_ov), 64'd1);
    chk("bp_dat", a_od, 64'h0000_00B0_0000_0020);
    chk("bp_pending", 64'(pa.size()), 64'd3);
    a_or = 1'b1; a_v0 = 1'b0; a_v1 = 1'b0;
    repeat (6) tick();
    chk("bp_drained", 64'(pa.size()), 64'd0);
    chk("bp_idle", 64'(a_ov), 64'd0);

    // Randomized traffic on A
    for (int i = 0; i < 400; i++) begin
      a_v0 = 1'($urandom_range(0, 1));
      a_v1 = 1'($urandom_range(0, 1));
      a_d0 = $urandom;
      a_d1 = $urandom;
      a_or = ($urandom_range(0, 3) != 0);
      tick();
    end
    a_v0 = 1'b0; a_v1 = 1'b0; a_or = 1'b1;
    repeat (6) tick();
    chk("rnd_drained", 64'(pa.size()), 64'd0);

    // Handshake counting from a fresh reset, then a mid-run reset
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    a_v0 = 1'b1; a_v1 = 1'b1; a_or = 1'b1;
    hs0 = a_out_cnt;
    for (int i = 0; i < 50 && (a_out_cnt - hs0) < 10; i++) begin
      a_d0 = 32'h300 + 32'(i); a_d1 = 32'h400 + 32'(i);
      tick();
    end
    chk("stat_hs", 64'(a_out_cnt - hs0), 64'd10);
`ifdef PAIR_COMBINER_STAT_EN
    chk("stat_cnt10", 64'(a_pc), 64'd10);
`endif
    rst_n = 1'b0;
    tick();
    chk("midrst_vld", 64'(a_ov), 64'd0);
    chk("midrst_rdy0", 64'(a_r0), 64'd0);
`ifdef PAIR_COMBINER_STAT_EN
    chk("midrst_cnt", 64'(a_pc), 64'd0);
`endif
    rst_n = 1'b1;
    a_v0 = 1'b0; a_v1 = 1'b0;
    repeat (3) tick();
    chk("midrst_no_stale", 64'(a_ov), 64'd0);

    // BURST "no": continuous valid, one pair every other cycle
    b_v0 = 1'b1; b_v1 = 1'b1; b_or = 1'b1;
    repeat (2) tick();
    n0 = b_out;
    repeat (8) tick();
    chk("b_rate", 64'(b_out - n0), 64'd4);
    b_v0 = 1'b0; b_v1 = 1'b0;
    repeat (4) tick();
    chk("b_no_loss", 64'(b_out), 64'(b_in0));
    chk("b_lanes_equal", 64'(b_in1), 64'(b_in0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
